// File: rtl/updown_counter_ctrl_if.sv
// Host-side command/status bundle for updown_counter_ctrl; the host sequencer is master.
interface updown_counter_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_dir;
   logic [7:0] cmd_preset;
   logic [7:0] cmd_periods;
   logic       pause_req;
   logic       abort;
   logic       busy;
   logic       done;
   logic [1:0] status;
   logic [8:0] periods_done;

   modport master (
      output cmd_valid, cmd_dir, cmd_preset, cmd_periods, pause_req, abort,
      input  cmd_ready, busy, done, status, periods_done
   );

   modport slave (
      input  cmd_valid, cmd_dir, cmd_preset, cmd_periods, pause_req, abort,
      output cmd_ready, busy, done, status, periods_done
   );
endinterface

// File: rtl/updown_counter_ctrl.sv
// Sequences preset load, enable edge and expiry counting for the 8-bit up/down counter; one command at a time,
// cmd_ready only in IDLE. Optional RUN watchdog (status 10) built when UPDOWN_CTRL_TIMEOUT_EN is defined.
module updown_counter_ctrl #(
   parameter int GAP_CYCLES     = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                 clk,
   input  logic                 resetb,
   updown_counter_ctrl_if.slave host,
   output logic                 new_cntr_preset,
   output logic [7:0]           new_cntr_preset_value,
   output logic                 enable_cnt_up,
   output logic                 enable_cnt_dn,
   output logic                 pause_counting,
   input  logic                 ctr_expired
);

   if (GAP_CYCLES < 2 || GAP_CYCLES > 256) begin : g_bad_gap
      $error("updown_counter_ctrl: GAP_CYCLES must be in 2..256");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("updown_counter_ctrl: TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_GAP,
      S_RUN,
      S_FINISH
   } state_t;

   localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);
   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_ABORT   = 2'b01;
   localparam logic [1:0] ST_TIMEOUT = 2'b10;

   state_t     state_q, state_d;
   logic       dir_q, dir_d;
   logic [7:0] preset_q, preset_d;
   logic [8:0] target_q, target_d;
   logic [8:0] periods_done_q, periods_done_d;
   logic [1:0] status_q, status_d;
   logic [7:0] gap_cnt_q, gap_cnt_d;
   logic       pause_d1_q;
   logic       in_run;
   logic       qual_exp;
   logic       wdog_fire;
   logic [8:0] periods_inc;

   assign in_run = (state_q == S_RUN);

   // An expiry that was still asserted across a paused cycle belongs to that pause and is not recounted.
   assign qual_exp = in_run & ctr_expired & ~pause_d1_q;

`ifdef UPDOWN_CTRL_TIMEOUT_EN
   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wdog_q, wdog_d;

   always_comb begin
      wdog_d    = '0;
      wdog_fire = 1'b0;
      if (in_run) begin
         if (qual_exp) begin
            wdog_d = '0;
         end else if (!host.pause_req) begin
            wdog_d    = wdog_q + 16'd1;
            wdog_fire = (wdog_q == WDOG_LAST);
         end else begin
            wdog_d = wdog_q;
         end
      end
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end
`else
   assign wdog_fire = 1'b0;
`endif

   always_comb begin
      state_d        = state_q;
      dir_d          = dir_q;
      preset_d       = preset_q;
      target_d       = target_q;
      periods_done_d = periods_done_q;
      status_d       = status_q;
      gap_cnt_d      = gap_cnt_q;
      periods_inc    = periods_done_q + 9'd1;

      case (state_q)
         S_IDLE: begin
            if (host.cmd_valid) begin
               dir_d          = host.cmd_dir;
               preset_d       = host.cmd_preset;
               target_d       = (host.cmd_periods == 8'd0) ? 9'd256 : {1'b0, host.cmd_periods};
               periods_done_d = '0;
               state_d        = S_LOAD;
            end
         end

         S_LOAD: begin
            gap_cnt_d = '0;
            if (host.abort) begin
               status_d = ST_ABORT;
               state_d  = S_FINISH;
            end else begin
               state_d = S_GAP;
            end
         end

         S_GAP: begin
            if (host.abort) begin
               status_d = ST_ABORT;
               state_d  = S_FINISH;
            end else if (gap_cnt_q == GAP_LAST) begin
               state_d = S_RUN;
            end else begin
               gap_cnt_d = gap_cnt_q + 8'd1;
            end
         end

         S_RUN: begin
            if (qual_exp) begin
               periods_done_d = periods_inc;
            end
            if (host.abort) begin
               status_d = ST_ABORT;
               state_d  = S_FINISH;
            end else if (wdog_fire) begin
               status_d = ST_TIMEOUT;
               state_d  = S_FINISH;
            end else if (qual_exp && (periods_inc == target_q)) begin
               status_d = ST_OK;
               state_d  = S_FINISH;
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_q        <= S_IDLE;
         dir_q          <= 1'b0;
         preset_q       <= '0;
         target_q       <= '0;
         periods_done_q <= '0;
         status_q       <= '0;
         gap_cnt_q      <= '0;
         pause_d1_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         dir_q          <= dir_d;
         preset_q       <= preset_d;
         target_q       <= target_d;
         periods_done_q <= periods_done_d;
         status_q       <= status_d;
         gap_cnt_q      <= gap_cnt_d;
         pause_d1_q     <= pause_counting;
      end
   end

   // Enables are decoded from state so they drop in the same cycle FINISH is entered.
   assign enable_cnt_up         = in_run &  dir_q;
   assign enable_cnt_dn         = in_run & ~dir_q;
   assign pause_counting        = in_run & host.pause_req;
   assign new_cntr_preset       = (state_q == S_LOAD);
   assign new_cntr_preset_value = preset_q;

   assign host.cmd_ready    = (state_q == S_IDLE);
   assign host.busy         = (state_q != S_IDLE);
   assign host.done         = (state_q == S_FINISH);
   assign host.status       = status_q;
   assign host.periods_done = periods_done_q;

endmodule

// File: tb/tb_updown_counter_ctrl.sv
// Directed bench for updown_counter_ctrl; expected completions are queued at command issue and popped on done.
module tb_updown_counter_ctrl;
   localparam int GAP = 2;
   localparam int TMO = 20;

   typedef struct packed {
      logic [1:0] status;
      logic [8:0] periods;
   } exp_t;

   logic       clk = 1'b0;
   logic       resetb;
   logic       new_cntr_preset;
   logic [7:0] new_cntr_preset_value;
   logic       enable_cnt_up;
   logic       enable_cnt_dn;
   logic       pause_counting;
   logic       ctr_expired;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   updown_counter_ctrl_if bus ();

   updown_counter_ctrl #(
      .GAP_CYCLES     (GAP),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk                   (clk),
      .resetb                (resetb),
      .host                  (bus.slave),
      .new_cntr_preset       (new_cntr_preset),
      .new_cntr_preset_value (new_cntr_preset_value),
      .enable_cnt_up         (enable_cnt_up),
      .enable_cnt_dn         (enable_cnt_dn),
      .pause_counting        (pause_counting),
      .ctr_expired           (ctr_expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Completion scoreboard: every done pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 16'(bus.done), 16'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("sb_status", 16'(bus.status), 16'(e.status));
            chk("sb_periods_done", 16'(bus.periods_done), 16'(e.periods));
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse();
      ctr_expired = 1'b1;
      @(negedge clk);
      ctr_expired = 1'b0;
   endtask

   // Issues a command from IDLE and checks the LOAD/GAP/enable timeline; returns in the first RUN cycle.
   task automatic send_cmd(input logic dir, input logic [7:0] pre, input logic [7:0] per);
      chk("ready_before_cmd", 16'(bus.cmd_ready), 16'd1);
      bus.cmd_valid   = 1'b1;
      bus.cmd_dir     = dir;
      bus.cmd_preset  = pre;
      bus.cmd_periods = per;
      @(negedge clk);
      bus.cmd_valid  = 1'b0;
      bus.cmd_preset = ~pre;
      chk("busy_in_load", 16'(bus.busy), 16'd1);
      chk("ready_in_load", 16'(bus.cmd_ready), 16'd0);
      chk("preset_strobe_c1", 16'(new_cntr_preset), 16'd1);
      chk("preset_value_c1", 16'(new_cntr_preset_value), 16'(pre));
      chk("periods_cleared", 16'(bus.periods_done), 16'd0);
      for (int c = 2; c <= 2 + GAP; c++) begin
         @(negedge clk);
         chk($sformatf("preset_strobe_c%0d", c), 16'(new_cntr_preset), 16'd0);
         chk($sformatf("en_up_c%0d", c), 16'(enable_cnt_up), 16'((c == 2 + GAP) && dir));
         chk($sformatf("en_dn_c%0d", c), 16'(enable_cnt_dn), 16'((c == 2 + GAP) && !dir));
      end
      chk("preset_value_held", 16'(new_cntr_preset_value), 16'(pre));
   endtask

   initial begin
      logic sticky;

      bus.cmd_valid   = 1'b0;
      bus.cmd_dir     = 1'b0;
      bus.cmd_preset  = 8'd0;
      bus.cmd_periods = 8'd0;
      bus.pause_req   = 1'b0;
      bus.abort       = 1'b0;
      ctr_expired     = 1'b0;
      resetb          = 1'b1;
      #1 resetb = 1'b0;
      cyc(2);
      chk("rst_cmd_ready", 16'(bus.cmd_ready), 16'd1);
      chk("rst_busy", 16'(bus.busy), 16'd0);
      chk("rst_done", 16'(bus.done), 16'd0);
      chk("rst_status", 16'(bus.status), 16'd0);
      chk("rst_periods_done", 16'(bus.periods_done), 16'd0);
      chk("rst_preset_value", 16'(new_cntr_preset_value), 16'd0);
      chk("rst_enables", 16'({enable_cnt_up, enable_cnt_dn, new_cntr_preset}), 16'd0);
      resetb = 1'b1;
      cyc(1);

      // Up, preset 5, 3 periods, expiry every 6 cycles.
      sb.push_back('{status: 2'b00, periods: 9'd3});
      send_cmd(1'b1, 8'd5, 8'd3);
      for (int p = 1; p <= 3; p++) begin
         cyc(5);
         pulse();
         chk($sformatf("up_periods_%0d", p), 16'(bus.periods_done), 16'(p));
         chk($sformatf("up_done_%0d", p), 16'(bus.done), 16'(p == 3));
         chk($sformatf("up_en_%0d", p), 16'(enable_cnt_up), 16'(p != 3));
      end
      chk("up_status", 16'(bus.status), 16'b00);
      cyc(1);
      chk("up_back_idle", 16'({bus.cmd_ready, bus.busy, bus.done}), 16'b100);

      // Down, periods 0 means 256.
      sb.push_back('{status: 2'b00, periods: 9'd256});
      send_cmd(1'b0, 8'hA0, 8'd0);
      sticky = 1'b0;
      for (int i = 1; i <= 256; i++) begin
         pulse();
         if (i < 256) begin
            sticky = sticky | enable_cnt_up | bus.done;
            cyc(1);
            sticky = sticky | enable_cnt_up | bus.done;
         end
      end
      chk("dn_no_up_or_early_done", 16'(sticky), 16'd0);
      chk("dn_done_256", 16'(bus.done), 16'd1);
      chk("dn_periods_256", 16'(bus.periods_done), 16'd256);
      cyc(1);

      // Pause with expiry held high across it: counted once.
      send_cmd(1'b1, 8'd3, 8'd2);
      cyc(2);
      bus.pause_req = 1'b1;
      ctr_expired   = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("pause_mirror_%0d", k), 16'(pause_counting), 16'd1);
      end
      bus.pause_req = 1'b0;
      ctr_expired   = 1'b0;
      @(negedge clk);
      chk("pause_released", 16'(pause_counting), 16'd0);
      chk("pause_one_count", 16'(bus.periods_done), 16'd1);
      chk("pause_still_busy", 16'(bus.busy), 16'd1);
      sb.push_back('{status: 2'b01, periods: 9'd1});
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("run_abort_done", 16'(bus.done), 16'd1);
      chk("run_abort_status", 16'(bus.status), 16'b01);
      chk("run_abort_enables", 16'({enable_cnt_up, enable_cnt_dn}), 16'd0);
      @(negedge clk);
      bus.pause_req = 1'b1;
      bus.abort     = 1'b1;
      @(negedge clk);
      chk("idle_pause_blocked", 16'(pause_counting), 16'd0);
      chk("idle_abort_ignored", 16'({bus.busy, bus.done}), 16'd0);
      bus.pause_req = 1'b0;
      bus.abort     = 1'b0;
      @(negedge clk);

      // Abort during GAP (cycle 3): FINISH in cycle 4, no enable ever.
      sb.push_back('{status: 2'b01, periods: 9'd0});
      bus.cmd_valid   = 1'b1;
      bus.cmd_dir     = 1'b1;
      bus.cmd_preset  = 8'd9;
      bus.cmd_periods = 8'd5;
      sticky = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b0;
         sticky = sticky | enable_cnt_up | enable_cnt_dn;
         bus.abort = (c == 3);
         if (c == 4) begin
            chk("gap_abort_done", 16'(bus.done), 16'd1);
            chk("gap_abort_status", 16'(bus.status), 16'b01);
            chk("gap_abort_periods", 16'(bus.periods_done), 16'd0);
         end
      end
      chk("gap_abort_no_enable", 16'(sticky), 16'd0);
      chk("gap_abort_ready", 16'(bus.cmd_ready), 16'd1);

`ifdef UPDOWN_CTRL_TIMEOUT_EN
      // No expiry: watchdog fires after TMO unpaused RUN cycles.
      sb.push_back('{status: 2'b10, periods: 9'd0});
      send_cmd(1'b1, 8'd1, 8'd4);
      sticky = 1'b0;
      for (int c = 5; c < 4 + TMO; c++) begin
         @(negedge clk);
         sticky = sticky | bus.done;
      end
      chk("tmo_not_early", 16'(sticky), 16'd0);
      @(negedge clk);
      chk("tmo_done", 16'(bus.done), 16'd1);
      chk("tmo_status", 16'(bus.status), 16'b10);
      @(negedge clk);
`else
      // No watchdog: block stays in RUN until aborted.
      send_cmd(1'b1, 8'd1, 8'd4);
      sticky = 1'b0;
      for (int c = 0; c < 2 * TMO; c++) begin
         @(negedge clk);
         sticky = sticky | bus.done;
      end
      chk("no_tmo_no_done", 16'(sticky), 16'd0);
      chk("no_tmo_still_run", 16'({bus.busy, enable_cnt_up}), 16'b11);
      sb.push_back('{status: 2'b01, periods: 9'd0});
      bus.abort = 1'b1;
      @(negedge clk);
      bus.abort = 1'b0;
      chk("no_tmo_abort_done", 16'(bus.done), 16'd1);
      @(negedge clk);
`endif

      // Asynchronous reset mid-RUN, then a fresh command.
      send_cmd(1'b1, 8'h11, 8'd3);
      cyc(2);
      pulse();
      chk("pre_rst_periods", 16'(bus.periods_done), 16'd1);
      #2 resetb = 1'b0;
      #1;
      chk("arst_outputs", 16'({bus.busy, bus.done, bus.status, enable_cnt_up, enable_cnt_dn,
                               new_cntr_preset, pause_counting}), 16'd0);
      chk("arst_preset_value", 16'(new_cntr_preset_value), 16'd0);
      chk("arst_periods_done", 16'(bus.periods_done), 16'd0);
      chk("arst_cmd_ready", 16'(bus.cmd_ready), 16'd1);
      @(negedge clk);
      resetb = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 16'(bus.cmd_ready), 16'd1);
      sb.push_back('{status: 2'b00, periods: 9'd1});
      send_cmd(1'b0, 8'h07, 8'd1);
      cyc(1);
      pulse();
      chk("post_rst_done", 16'(bus.done), 16'd1);
      chk("post_rst_periods", 16'(bus.periods_done), 16'd1);
      cyc(2);
      chk("sb_drained", 16'(sb.size()), 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
